// File: rtl/vc_bus_responder.sv
// Target side of the vc core's byte-wide memory bus: parses cmd/addr/data frames and serves reads from a local byte RAM.
// Optional build macro VC_BUS_RESPONDER_RANGE_CHECK_EN flags addresses above the backing memory and raises err.
module vc_bus_responder #(
  parameter int PA         = 24,
  parameter int MEM_AW     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic       bus_req,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       bus_rdy,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, ADDR2, ADDR1, ADDR0, WDATA, WEND, RWAIT, RDATA
  } state_t;

  state_t         state, next_state;
  logic           is_write;
  logic           size;
  logic           bytes_left;
  logic [3:0]     lat_cnt;
  logic [PA-1:0]  addr;
  logic [PA-1:0]  cur_addr;
  logic           emit;
  logic           frame_oor;
  logic [7:0]     rd_byte;
  logic           oe_d, rdy_d, busy_d;
  logic [7:0]     mem [0:(1<<MEM_AW)-1];

  // In ADDR0 the low address byte is still on the bus, so the full address is assembled on the fly
  assign cur_addr = (state == ADDR0) ? {addr[PA-9:0], bus_in} : addr;
  assign emit     = (next_state == RDATA);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus_req) next_state = ADDR2;
      ADDR2: next_state = bus_req ? ADDR1 : IDLE;
      ADDR1: next_state = bus_req ? ADDR0 : IDLE;
      ADDR0: begin
        if (!bus_req)             next_state = IDLE;
        else if (is_write)        next_state = WDATA;
        else if (RD_LATENCY == 0) next_state = RDATA;
        else                      next_state = RWAIT;
      end
      WDATA: begin
        if (!bus_req)                next_state = IDLE;
        else if (bytes_left == 1'b0) next_state = WEND;
      end
      WEND:  if (!bus_req) next_state = IDLE;
      RWAIT: if (lat_cnt <= 4'd1) next_state = RDATA;
      RDATA: if (bytes_left == 1'b0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    oe_d    = emit;
    rdy_d   = emit;
    busy_d  = (next_state != IDLE);
    rd_byte = frame_oor ? 8'hFF : mem[cur_addr[MEM_AW-1:0]];
  end

  // Data bytes are fetched one cycle ahead so bus_out is registered while bus_rdy is high
  always_ff @(posedge clk) begin
    if (reset) begin
      is_write   <= 1'b0;
      size       <= 1'b0;
      bytes_left <= 1'b0;
      lat_cnt    <= 4'd0;
      addr       <= '0;
      bus_out    <= 8'h00;
      bus_oe     <= 1'b0;
      bus_rdy    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bus_oe  <= oe_d;
      bus_rdy <= rdy_d;
      busy    <= busy_d;
      bus_out <= emit ? rd_byte : 8'h00;
      case (state)
        IDLE: if (bus_req) begin
          is_write <= bus_in[7];
          size     <= bus_in[0];
        end
        ADDR2: if (bus_req) addr <= PA'(bus_in);
        ADDR1: if (bus_req) addr <= {addr[PA-9:0], bus_in};
        ADDR0: if (bus_req) begin
          addr       <= cur_addr;
          bytes_left <= size;
          lat_cnt    <= 4'(RD_LATENCY);
        end
        WDATA: if (bus_req) begin
          addr <= addr + PA'(1);
          if (bytes_left != 1'b0) bytes_left <= bytes_left - 1'b1;
        end
        RWAIT: lat_cnt <= lat_cnt - 4'd1;
        default: ;
      endcase
      if (emit) begin
        addr <= cur_addr + PA'(1);
        if (state == RDATA && bytes_left != 1'b0) bytes_left <= bytes_left - 1'b1;
      end
    end
  end

  // Memory contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!reset && state == WDATA && bus_req && !frame_oor)
      mem[addr[MEM_AW-1:0]] <= bus_in;
  end

`ifdef VC_BUS_RESPONDER_RANGE_CHECK_EN
  logic oor_q, err_q, hi_nz;

  assign hi_nz     = (cur_addr >> MEM_AW) != '0;
  assign frame_oor = (state == ADDR0) ? hi_nz : oor_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state == IDLE && bus_req) begin
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state == ADDR0 && bus_req) begin
      oor_q <= hi_nz;
      err_q <= hi_nz;
    end
  end
`else
  assign frame_oor = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_vc_bus_responder.sv
// Directed bench for vc_bus_responder: two instances share stimulus, one with read latency 2 and one with latency 0.
module tb_vc_bus_responder;

`ifdef VC_BUS_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       bus_req;
  logic [7:0] bus_out, bus_out0;
  logic       bus_oe, bus_oe0, bus_rdy, bus_rdy0, busy, busy0, err, err0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  vc_bus_responder #(.PA(24), .MEM_AW(8), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_req(bus_req),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_rdy(bus_rdy), .busy(busy), .err(err)
  );

  vc_bus_responder #(.PA(24), .MEM_AW(8), .RD_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_req(bus_req),
    .bus_out(bus_out0), .bus_oe(bus_oe0), .bus_rdy(bus_rdy0), .busy(busy0), .err(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus_req = 1'b1;
    bus_in  = b;
    tick();
  endtask

  task automatic idleCycle();
    bus_req = 1'b0;
    bus_in  = 8'h00;
    tick();
  endtask

  task automatic writeFrame(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input bit two);
    applyStimulus({1'b1, 6'b0, two});
    checkOutput("wr busy", 16'(busy), 16'd1);
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
    applyStimulus(d0);
    if (two) applyStimulus(d1);
    idleCycle();
    checkOutput("wr end busy", 16'(busy), 16'd0);
  endtask

  // k is the ADDR0 cycle; latency-0 data appears at k+1, latency-2 data at k+3
  task automatic readFrame(input logic [23:0] a, input bit two, input logic [7:0] e0,
                           input logic [7:0] e1, input logic exp_err, input string tag);
    applyStimulus({7'b0, two});
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
    bus_req = 1'b0;
    bus_in  = 8'h00;
    checkOutput({tag, " lat0 rdy k+1"}, 16'(bus_rdy0), 16'd1);
    checkOutput({tag, " lat0 data0"}, 16'(bus_out0), 16'(e0));
    checkOutput({tag, " rdy k+1"}, 16'(bus_rdy), 16'd0);
    checkOutput({tag, " busy k+1"}, 16'(busy), 16'd1);
    checkOutput({tag, " err"}, 16'(err), 16'(exp_err));
    tick();
    checkOutput({tag, " rdy k+2"}, 16'(bus_rdy), 16'd0);
    checkOutput({tag, " lat0 rdy k+2"}, 16'(bus_rdy0), 16'(two));
    if (two) checkOutput({tag, " lat0 data1"}, 16'(bus_out0), 16'(e1));
    tick();
    checkOutput({tag, " rdy k+3"}, 16'(bus_rdy), 16'd1);
    checkOutput({tag, " oe k+3"}, 16'(bus_oe), 16'd1);
    checkOutput({tag, " data0"}, 16'(bus_out), 16'(e0));
    checkOutput({tag, " lat0 busy k+3"}, 16'(busy0), 16'd0);
    tick();
    if (two) begin
      checkOutput({tag, " rdy k+4"}, 16'(bus_rdy), 16'd1);
      checkOutput({tag, " data1"}, 16'(bus_out), 16'(e1));
      tick();
    end
    checkOutput({tag, " rdy end"}, 16'(bus_rdy), 16'd0);
    checkOutput({tag, " oe end"}, 16'(bus_oe), 16'd0);
    checkOutput({tag, " busy end"}, 16'(busy), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset   = 1'b1;
    bus_req = 1'b0;
    bus_in  = 8'h00;
    tick(); tick(); tick();
    checkOutput("rst bus_out", 16'(bus_out), 16'h00);
    checkOutput("rst oe", 16'(bus_oe), 16'd0);
    checkOutput("rst rdy", 16'(bus_rdy), 16'd0);
    checkOutput("rst busy", 16'(busy), 16'd0);
    checkOutput("rst err", 16'(err), 16'd0);
    reset = 1'b0;
    tick();
    checkOutput("post rst busy", 16'(busy), 16'd0);

    // Byte write then byte read
    writeFrame(24'h000010, 8'hA5, 8'h00, 1'b0);
    readFrame(24'h000010, 1'b0, 8'hA5, 8'h00, 1'b0, "byte");

    // Halfword write across the top of memory wraps to 0x00
    writeFrame(24'h0000FF, 8'h34, 8'h12, 1'b1);
    readFrame(24'h0000FF, 1'b1, 8'h34, 8'h12, 1'b0, "half wrap");
    readFrame(24'h000000, 1'b0, 8'h12, 8'h00, 1'b0, "wrap byte");

    // Abort after the first of two data bytes
    writeFrame(24'h000020, 8'hC3, 8'h3C, 1'b1);
    applyStimulus(8'h81);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h20);
    applyStimulus(8'h77);
    checkOutput("abort busy in data", 16'(busy), 16'd1);
    idleCycle();
    checkOutput("abort idle", 16'(busy), 16'd0);
    readFrame(24'h000020, 1'b1, 8'h77, 8'h3C, 1'b0, "after abort");

    // Reset on the first data cycle of a read
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    idleCycle();
    idleCycle();
    checkOutput("pre rst rdy", 16'(bus_rdy), 16'd1);
    checkOutput("pre rst data", 16'(bus_out), 16'h34);
    reset = 1'b1;
    tick();
    checkOutput("mid rst oe", 16'(bus_oe), 16'd0);
    checkOutput("mid rst rdy", 16'(bus_rdy), 16'd0);
    checkOutput("mid rst busy", 16'(busy), 16'd0);
    reset = 1'b0;
    idleCycle();
    readFrame(24'h0000FF, 1'b1, 8'h34, 8'h12, 1'b0, "after rst");

    // High address bits: flagged with range check, aliased without it
    writeFrame(24'h000110, 8'h5A, 8'h00, 1'b0);
    checkOutput("oor wr err", 16'(err), 16'(RC));
    readFrame(24'h000110, 1'b0, RC ? 8'hFF : 8'h5A, 8'h00, RC, "oor rd");
    checkOutput("oor err held", 16'(err), 16'(RC));
    readFrame(24'h000010, 1'b0, RC ? 8'hA5 : 8'h5A, 8'h00, 1'b0, "in range rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
